// File: rtl/bus_rx_pkg.sv
// Shared types and defaults for the bus monitor capture path.
// The record layout follows the default parameter set of bus_rx_capture.
package bus_rx_pkg;

  localparam int DRVRS_DEF   = 4;
  localparam int PCKG_SZ_DEF = 16;
  localparam int DEPTH_DEF   = 8;
  localparam int TS_W_DEF    = 32;
  localparam int DEV_W_DEF   = $clog2(DRVRS_DEF);

  localparam logic [7:0] BCAST_ID = 8'hFF;

  typedef struct packed {
    logic [DEV_W_DEF-1:0]   dev;
    logic [TS_W_DEF-1:0]    ts;
    logic [PCKG_SZ_DEF-1:0] pckg;
  } rx_rec_t;

  // Index of the device 'off' positions after 'base' in a ring of n devices.
  function automatic int rr_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Generic synchronous FIFO of DEPTH records with full/empty flags.
// Read data is the head entry and only changes when an entry is popped.
module rx_sync_fifo
  import bus_rx_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = rx_rec_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_wr_en,
  input  T     i_wr_data,
  input  logic i_rd_en,
  output T     o_rd_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_wr;
  logic           w_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/bus_rx_capture.sv
// Capture front-end: per-device staging, round-robin arbitration into one FIFO.
// Optional destination-ID check is built when BUS_RX_ADDR_CHECK_EN is defined.
module bus_rx_capture
  import bus_rx_pkg::*;
#(
  parameter int DRVRS   = DRVRS_DEF,
  parameter int PCKG_SZ = PCKG_SZ_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TS_W    = TS_W_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [DRVRS-1:0]                 push_i,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]    D_push_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [PCKG_SZ-1:0]               out_pckg_o,
  output logic [$clog2(DRVRS)-1:0]         out_dev_o,
  output logic [TS_W-1:0]                  out_ts_o,
  output logic [15:0]                      drop_cnt_o,
  output logic                             addr_err_o
);

  localparam int DEV_W = $clog2(DRVRS);
  localparam int DN_W  = $clog2(DRVRS + 1);

  logic [TS_W-1:0]                 r_ts;
  logic [DRVRS-1:0]                r_stg_vld;
  logic [DRVRS-1:0][PCKG_SZ-1:0]   r_stg_pckg;
  logic [DRVRS-1:0][TS_W-1:0]      r_stg_ts;
  logic [DEV_W-1:0]                r_rr;
  logic [15:0]                     r_drop_cnt;

  logic                            w_gnt_vld;
  logic [DEV_W-1:0]                w_gnt_idx;
  logic                            w_full;
  logic                            w_empty;
  logic                            w_pop;
  logic                            w_wr;
  logic [DRVRS-1:0]                w_gnt_oh;
  logic [DRVRS-1:0]                w_load;
  logic [DRVRS-1:0]                w_drop;
  logic [DN_W-1:0]                 w_drop_n;
  logic [16:0]                     w_drop_sum;
  rx_rec_t                         w_wr_rec;
  rx_rec_t                         w_rd_rec;

  // Output handshake: a record transfers on any rising edge where
  // out_valid_o && out_ready_i; while valid and not ready the fields hold.
  assign w_pop = out_valid_o && out_ready_i;
  assign w_wr  = w_gnt_vld && (!w_full || w_pop);

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < DRVRS; k++) begin
      if (!w_gnt_vld && r_stg_vld[rr_idx(int'(r_rr), k, DRVRS)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = DEV_W'(rr_idx(int'(r_rr), k, DRVRS));
      end
    end
  end

  // A granted slot can accept a new packet in the same cycle it drains.
  always_comb begin
    w_gnt_oh = '0;
    w_load   = '0;
    w_drop   = '0;
    w_drop_n = '0;
    for (int i = 0; i < DRVRS; i++) begin
      w_gnt_oh[i] = w_wr && (w_gnt_idx == DEV_W'(i));
      w_load[i]   = push_i[i] && (!r_stg_vld[i] || w_gnt_oh[i]);
      w_drop[i]   = push_i[i] && r_stg_vld[i] && !w_gnt_oh[i];
      w_drop_n    = w_drop_n + DN_W'(w_drop[i]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);

  always_comb begin
    w_wr_rec      = '0;
    w_wr_rec.dev  = w_gnt_idx;
    w_wr_rec.ts   = r_stg_ts[w_gnt_idx];
    w_wr_rec.pckg = r_stg_pckg[w_gnt_idx];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ts       <= '0;
      r_stg_vld  <= '0;
      r_stg_pckg <= '0;
      r_stg_ts   <= '0;
      r_rr       <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ts       <= r_ts + 1'b1;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      for (int i = 0; i < DRVRS; i++) begin
        if (w_load[i]) begin
          r_stg_vld[i]  <= 1'b1;
          r_stg_pckg[i] <= D_push_i[i];
          r_stg_ts[i]   <= r_ts;
        end else if (w_gnt_oh[i]) begin
          r_stg_vld[i] <= 1'b0;
        end
      end
      if (w_wr) begin
        r_rr <= (w_gnt_idx == DEV_W'(DRVRS - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  rx_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (rx_rec_t)
  ) u_fifo (
    .i_clk     (clk_i),
    .i_rst_n   (rst_n_i),
    .i_wr_en   (w_wr),
    .i_wr_data (w_wr_rec),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_rec),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Fields read as zero whenever nothing is presented, including during reset.
  assign out_valid_o = !w_empty;
  assign out_pckg_o  = out_valid_o ? w_rd_rec.pckg : '0;
  assign out_dev_o   = out_valid_o ? w_rd_rec.dev  : '0;
  assign out_ts_o    = out_valid_o ? w_rd_rec.ts   : '0;
  assign drop_cnt_o  = r_drop_cnt;

`ifdef BUS_RX_ADDR_CHECK_EN
  logic             r_addr_err;
  logic [DRVRS-1:0] w_bad;

  always_comb begin
    w_bad = '0;
    for (int i = 0; i < DRVRS; i++) begin
      w_bad[i] = w_load[i] &&
                 (D_push_i[i][PCKG_SZ-1 -: 8] != 8'(i)) &&
                 (D_push_i[i][PCKG_SZ-1 -: 8] != BCAST_ID);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr_err <= 1'b0;
    end else if (|w_bad) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err_o = r_addr_err;
`else
  assign addr_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rx_capture.sv
// Directed bench for bus_rx_capture; set BUS_RX_ADDR_CHECK_EN to exercise the address check.
module tb_bus_rx_capture;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic [3:0]       push_i;
  logic [3:0][15:0] d_push;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [15:0]      out_pckg_o;
  logic [1:0]       out_dev_o;
  logic [31:0]      out_ts_o;
  logic [15:0]      drop_cnt_o;
  logic             addr_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk_i = ~clk_i;

  // Bench-side cycle reference for expected timestamps.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  bus_rx_capture dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push_i),
    .D_push_i    (d_push),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pckg_o  (out_pckg_o),
    .out_dev_o   (out_dev_o),
    .out_ts_o    (out_ts_o),
    .drop_cnt_o  (drop_cnt_o),
    .addr_err_o  (addr_err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i     = 1'b0;
    push_i      = '0;
    d_push      = '0;
    out_ready_i = 1'b1;
    #3;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; push_i = '0; d_push = '0; out_ready_i = 1'b1;
    #3;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    n_checks++; if (out_pckg_o !== 16'h0) begin n_fail++; $display("FAIL reset_pckg: got %h want 0", out_pckg_o); end
    n_checks++; if (out_dev_o !== 2'd0) begin n_fail++; $display("FAIL reset_dev: got %0d want 0", out_dev_o); end
    n_checks++; if (out_ts_o !== 32'd0) begin n_fail++; $display("FAIL reset_ts: got %0d want 0", out_ts_o); end
    n_checks++; if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
    n_checks++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b want 0", addr_err_o); end
    tick();
    rst_n_i = 1'b1;
    tick();
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", out_valid_o); end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 20 && cyc != 10; k++) tick();
    push_i = 4'b0100; d_push[2] = 16'h02CC;
    tick();
    push_i = '0;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_t1_valid: got %b want 0", out_valid_o); end
    tick();
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid_o); end
    n_checks++; if (out_pckg_o !== 16'h02CC) begin n_fail++; $display("FAIL single_pckg: got %h want 02cc", out_pckg_o); end
    n_checks++; if (out_dev_o !== 2'd2) begin n_fail++; $display("FAIL single_dev: got %0d want 2", out_dev_o); end
    n_checks++; if (out_ts_o !== 32'd10) begin n_fail++; $display("FAIL single_ts: got %0d want 10", out_ts_o); end
    tick();
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_valid_o); end
    // rr now points at device 3, so 3 wins over 0.
    push_i = 4'b1001; d_push[0] = 16'h0001; d_push[3] = 16'h0303;
    tick();
    push_i = '0;
    tick();
    n_checks++; if (out_dev_o !== 2'd3) begin n_fail++; $display("FAIL rr_wrap_first: got %0d want 3", out_dev_o); end
    tick();
    n_checks++; if (out_dev_o !== 2'd0 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL rr_wrap_second: got dev %0d valid %b want dev 0 valid 1", out_dev_o, out_valid_o); end
  endtask

  task automatic test_simultaneous();
    int exp_ts;
    do_reset();
    tick();
    tick();
    exp_ts = cyc;
    push_i = 4'b1111;
    for (int i = 0; i < 4; i++) d_push[i] = 16'(i * 256 + 16'hB0 + i);
    tick();
    push_i = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_dev_o !== 2'(i) || out_pckg_o !== 16'(i * 256 + 16'hB0 + i) || out_ts_o !== 32'(exp_ts)) begin
        n_fail++;
        $display("FAIL simul_rec%0d: got v=%b dev=%0d pckg=%h ts=%0d want v=1 dev=%0d pckg=%h ts=%0d",
                 i, out_valid_o, out_dev_o, out_pckg_o, out_ts_o, i, 16'(i * 256 + 16'hB0 + i), exp_ts);
      end
      tick();
    end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL simul_drain: got %b want 0", out_valid_o); end
    // rr back at 0: device 0 must beat device 3.
    push_i = 4'b1001; d_push[0] = 16'h00C0; d_push[3] = 16'h03C3;
    tick();
    push_i = '0;
    tick();
    n_checks++; if (out_dev_o !== 2'd0) begin n_fail++; $display("FAIL simul_rr_zero: got %0d want 0", out_dev_o); end
    tick();
    n_checks++; if (out_dev_o !== 2'd3) begin n_fail++; $display("FAIL simul_rr_next: got %0d want 3", out_dev_o); end
  endtask

  task automatic test_backpressure();
    int t0;
    do_reset();
    out_ready_i = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      push_i = 4'b0010; d_push[1] = 16'h0100 + 16'(k);
      tick();
    end
    push_i = '0;
    tick();
    tick();
    n_checks++; if (drop_cnt_o !== 16'd3) begin n_fail++; $display("FAIL bp_drop: got %0d want 3", drop_cnt_o); end
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_pckg_o !== 16'h0100 || out_dev_o !== 2'd1 || out_ts_o !== 32'(t0)) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got v=%b pckg=%h dev=%0d ts=%0d want v=1 pckg=0100 dev=1 ts=%0d",
                 s, out_valid_o, out_pckg_o, out_dev_o, out_ts_o, t0);
      end
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_pckg_o !== 16'h0100 + 16'(k) || out_ts_o !== 32'(t0 + k)) begin
        n_fail++;
        $display("FAIL bp_drain%0d: got v=%b pckg=%h ts=%0d want v=1 pckg=%h ts=%0d",
                 k, out_valid_o, out_pckg_o, out_ts_o, 16'h0100 + 16'(k), t0 + k);
      end
      tick();
    end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid_o); end
    n_checks++; if (drop_cnt_o !== 16'd3) begin n_fail++; $display("FAIL bp_drop_hold: got %0d want 3", drop_cnt_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_i = 4'b0001; d_push[0] = 16'h00E1;
    tick();
    d_push[0] = 16'h00E2;
    tick();
    push_i = '0;
    n_checks++; if (out_valid_o !== 1'b1 || out_pckg_o !== 16'h00E1) begin n_fail++; $display("FAIL b2b_first: got v=%b pckg=%h want v=1 pckg=00e1", out_valid_o, out_pckg_o); end
    tick();
    n_checks++; if (out_valid_o !== 1'b1 || out_pckg_o !== 16'h00E2) begin n_fail++; $display("FAIL b2b_second: got v=%b pckg=%h want v=1 pckg=00e2", out_valid_o, out_pckg_o); end
    tick();
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid_o); end
    n_checks++; if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_addr_check();
    logic exp_err;
`ifdef BUS_RX_ADDR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    push_i = 4'b1000; d_push[3] = 16'hFF11;
    tick();
    push_i = '0;
    n_checks++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL addr_bcast: got %b want 0", addr_err_o); end
    tick();
    n_checks++; if (out_pckg_o !== 16'hFF11) begin n_fail++; $display("FAIL addr_bcast_rec: got %h want ff11", out_pckg_o); end
    tick();
    push_i = 4'b1000; d_push[3] = 16'h00DA;
    tick();
    push_i = '0;
    n_checks++; if (addr_err_o !== exp_err) begin n_fail++; $display("FAIL addr_err_set: got %b want %b", addr_err_o, exp_err); end
    tick();
    n_checks++; if (out_valid_o !== 1'b1 || out_pckg_o !== 16'h00DA || out_dev_o !== 2'd3) begin n_fail++; $display("FAIL addr_err_rec: got v=%b pckg=%h dev=%0d want v=1 pckg=00da dev=3", out_valid_o, out_pckg_o, out_dev_o); end
    tick();
    tick();
    n_checks++; if (addr_err_o !== exp_err) begin n_fail++; $display("FAIL addr_err_sticky: got %b want %b", addr_err_o, exp_err); end
  endtask

  task automatic test_reset_mid();
    int stale;
    do_reset();
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_i = 4'b0001; d_push[0] = 16'h0030 + 16'(k);
      tick();
    end
    push_i = '0;
    tick();
    n_checks++; if (out_valid_o !== 1'b1 || out_pckg_o !== 16'h0030) begin n_fail++; $display("FAIL mid_pre: got v=%b pckg=%h want v=1 pckg=0030", out_valid_o, out_pckg_o); end
    #2;
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (out_valid_o !== 1'b0 || out_pckg_o !== 16'h0 || out_dev_o !== 2'd0 || out_ts_o !== 32'd0 || drop_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_async: got v=%b pckg=%h dev=%0d ts=%0d drop=%0d want all 0",
               out_valid_o, out_pckg_o, out_dev_o, out_ts_o, drop_cnt_o);
    end
    tick();
    rst_n_i = 1'b1;
    out_ready_i = 1'b1;
    push_i = 4'b0100; d_push[2] = 16'h0255;
    tick();
    push_i = '0;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b want 0", out_valid_o); end
    tick();
    n_checks++;
    if (out_valid_o !== 1'b1 || out_pckg_o !== 16'h0255 || out_dev_o !== 2'd2 || out_ts_o !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_restart: got v=%b pckg=%h dev=%0d ts=%0d want v=1 pckg=0255 dev=2 ts=0",
               out_valid_o, out_pckg_o, out_dev_o, out_ts_o);
    end
    tick();
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid_o !== 1'b0) stale++;
      tick();
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL mid_no_extra: got %0d extra valid cycles want 0", stale); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_back_to_back();
    test_addr_check();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
